// File: rtl/rotation_mem_bridge_if.sv
// Port bundles for the rotation buffer bridge: the video-pipeline side
// (vidin write bursts, vidout read bursts) and the generic SDRAM-controller side.
interface rotation_vid_if;
  logic        vidin_req;
  logic        vidin_frame;
  logic [9:0]  vidin_row;
  logic [9:0]  vidin_col;
  logic [15:0] vidin_d;
  logic        vidin_ack;
  logic        vidout_req;
  logic        vidout_frame;
  logic [9:0]  vidout_row;
  logic [9:0]  vidout_col;
  logic [15:0] vidout_d;
  logic        vidout_ack;

  modport master (
    output vidin_req, vidin_frame, vidin_row, vidin_col, vidin_d,
    output vidout_req, vidout_frame, vidout_row, vidout_col,
    input  vidin_ack, vidout_d, vidout_ack
  );

  modport slave (
    input  vidin_req, vidin_frame, vidin_row, vidin_col, vidin_d,
    input  vidout_req, vidout_frame, vidout_row, vidout_col,
    output vidin_ack, vidout_d, vidout_ack
  );
endinterface

interface rotation_mem_if #(
  parameter int ADDR_WIDTH = 24
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic [15:0]           mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/rotation_mem_bridge.sv
// Rotation buffer memory responder: turns vidin write bursts and vidout read
// bursts into single-word SDRAM-controller requests, alternating under contention.
module rotation_mem_bridge #(
  parameter int                    ADDR_WIDTH   = 24,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(24'h000000),
  parameter logic [ADDR_WIDTH-1:0] FRAME_OFFSET = ADDR_WIDTH'(24'h080000),
  parameter int                    ROW_SHIFT    = 10,
  parameter int                    WR_BURST     = 16,
  parameter int                    RD_BURST     = 8
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  rotation_vid_if.slave  vid,
  rotation_mem_if.master mem
);

  localparam int BEAT_MAX = (WR_BURST > RD_BURST) ? WR_BURST : RD_BURST;
  localparam int BEAT_W   = $clog2(BEAT_MAX) + 1;

  localparam logic [BEAT_W-1:0] WR_LAST    = BEAT_W'(WR_BURST);
  localparam logic [BEAT_W-1:0] RD_LAST_M1 = BEAT_W'(RD_BURST - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_LOAD,
    S_WR_ISSUE,
    S_WR_NEXT,
    S_RD_ISSUE,
    S_HOLD
  } state_t;

  state_t                r_state;
  logic [BEAT_W-1:0]     r_beat;
  logic                  r_last_wr;
  logic                  r_cur_wr;
  logic [ADDR_WIDTH-1:0] r_base;

  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [15:0]           r_mem_wdata;
  logic                  r_vidin_ack;
  logic                  r_vidout_ack;
  logic [15:0]           r_vidout_d;

  logic                  w_grant_rd;
  logic                  w_grant_wr;
  logic                  w_ack;
  logic [BEAT_W-1:0]     w_beat_inc;
  logic [ADDR_WIDTH-1:0] w_wr_base;
  logic [ADDR_WIDTH-1:0] w_rd_base;

  function automatic logic [ADDR_WIDTH-1:0] f_base(
    input logic       frame,
    input logic [9:0] row,
    input logic [9:0] col
  );
    return BASE_ADDR + (frame ? FRAME_OFFSET : '0)
         + (ADDR_WIDTH'(row) << ROW_SHIFT) + ADDR_WIDTH'(col);
  endfunction

  assign w_wr_base  = f_base(vid.vidin_frame, vid.vidin_row, vid.vidin_col);
  assign w_rd_base  = f_base(vid.vidout_frame, vid.vidout_row, vid.vidout_col);
  assign w_beat_inc = r_beat + BEAT_W'(1);
  // A stray ack with no request outstanding must not advance a burst.
  assign w_ack      = mem.mem_ack & r_mem_req;

  always_comb begin
    w_grant_rd = 1'b0;
    w_grant_wr = 1'b0;
    if (vid.vidin_req && vid.vidout_req) begin
      w_grant_rd = r_last_wr;
      w_grant_wr = ~r_last_wr;
    end else begin
      w_grant_rd = vid.vidout_req;
      w_grant_wr = vid.vidin_req;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_beat       <= '0;
      r_last_wr    <= 1'b1;
      r_cur_wr     <= 1'b0;
      r_base       <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_vidin_ack  <= 1'b0;
      r_vidout_ack <= 1'b0;
      r_vidout_d   <= '0;
    end else begin
      r_vidin_ack  <= 1'b0;
      r_vidout_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_beat <= '0;
          if (w_grant_rd) begin
            r_cur_wr   <= 1'b0;
            r_base     <= w_rd_base;
            r_mem_addr <= w_rd_base;
            r_mem_we   <= 1'b0;
            r_mem_req  <= 1'b1;
            r_state    <= S_RD_ISSUE;
          end else if (w_grant_wr) begin
            r_cur_wr <= 1'b1;
            r_base   <= w_wr_base;
            r_state  <= S_WR_LOAD;
          end
        end

        S_WR_LOAD: begin
          r_mem_wdata <= vid.vidin_d;
          r_mem_addr  <= r_base + ADDR_WIDTH'(r_beat);
          r_mem_we    <= 1'b1;
          r_mem_req   <= 1'b1;
          r_state     <= S_WR_ISSUE;
        end

        S_WR_ISSUE: begin
          if (w_ack) begin
            r_mem_req   <= 1'b0;
            r_vidin_ack <= 1'b1;
            r_beat      <= w_beat_inc;
            r_state     <= S_WR_NEXT;
          end
        end

        S_WR_NEXT: begin
          if (r_beat == WR_LAST || !vid.vidin_req) begin
            r_state <= S_HOLD;
          end else begin
            r_state <= S_WR_LOAD;
          end
        end

        // Reads stream back-to-back: the next address follows each ack with req held.
        S_RD_ISSUE: begin
          if (w_ack) begin
            r_vidout_d   <= mem.mem_rdata;
            r_vidout_ack <= 1'b1;
            r_beat       <= w_beat_inc;
            if (r_beat == RD_LAST_M1 || !vid.vidout_req) begin
              r_mem_req <= 1'b0;
              r_state   <= S_HOLD;
            end else begin
              r_mem_addr <= r_base + ADDR_WIDTH'(w_beat_inc);
            end
          end
        end

        S_HOLD: begin
          r_beat    <= '0;
          r_mem_we  <= 1'b0;
          r_last_wr <= r_cur_wr;
          r_state   <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem.mem_req    = r_mem_req;
  assign mem.mem_we     = r_mem_we;
  assign mem.mem_addr   = r_mem_addr;
  assign mem.mem_wdata  = r_mem_wdata;
  assign vid.vidin_ack  = r_vidin_ack;
  assign vid.vidout_ack = r_vidout_ack;
  assign vid.vidout_d   = r_vidout_d;

endmodule

// File: tb/tb_rotation_mem_bridge.sv
// Directed bench for rotation_mem_bridge: contention, write/read bursts, abort,
// asynchronous reset mid-read and 20-bit address wrap on a second instance.
module tb_rotation_mem_bridge;

  logic clk_sys = 1'b0;
  logic reset_n;

  always #5 clk_sys = ~clk_sys;

  rotation_vid_if                    vid1 ();
  rotation_mem_if #(.ADDR_WIDTH(24)) mem1 ();
  rotation_vid_if                    vid2 ();
  rotation_mem_if #(.ADDR_WIDTH(20)) mem2 ();

  rotation_mem_bridge u_dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .vid     (vid1),
    .mem     (mem1)
  );

  rotation_mem_bridge #(
    .ADDR_WIDTH   (20),
    .BASE_ADDR    (20'hFFFF8),
    .FRAME_OFFSET (20'h80000)
  ) u_dut_wrap (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .vid     (vid2),
    .mem     (mem2)
  );

  // Zero-latency memory for the wrap instance: ack in the cycle of the request.
  assign mem2.mem_ack   = mem2.mem_req;
  assign mem2.mem_rdata = mem2.mem_addr[15:0];

  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 0;
  int          wait_cnt = 0;
  int          op_cnt = 0;
  int          vin_acks = 0;
  int          vout_acks = 0;
  int          overlap = 0;
  logic        op_we   [0:255];
  logic [23:0] op_addr [0:255];
  logic [15:0] op_data [0:255];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model for the main instance: acks after mem_lat waiting cycles, returns addr[15:0].
  always @(posedge clk_sys) begin
    #1;
    if (mem1.mem_req === 1'b1) begin
      if (wait_cnt >= mem_lat) begin
        mem1.mem_ack   = 1'b1;
        mem1.mem_rdata = mem1.mem_addr[15:0];
        if (op_cnt < 256) begin
          op_we[op_cnt]   = mem1.mem_we;
          op_addr[op_cnt] = mem1.mem_addr;
          op_data[op_cnt] = mem1.mem_wdata;
        end
        op_cnt++;
        wait_cnt = 0;
      end else begin
        mem1.mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem1.mem_ack   = 1'b0;
      mem1.mem_rdata = 16'h0000;
      wait_cnt       = 0;
    end
  end

  always @(negedge clk_sys) begin
    if (vid1.vidin_ack === 1'b1) vin_acks++;
    if (vid1.vidout_ack === 1'b1) vout_acks++;
    if (vid1.vidin_ack === 1'b1 && vid1.vidout_ack === 1'b1) overlap++;
  end

  initial begin
    int n0;
    int vin0;
    int acks;

    reset_n           = 1'b0;
    vid1.vidin_req    = 1'b1;
    vid1.vidin_frame  = 1'b0;
    vid1.vidin_row    = 10'd0;
    vid1.vidin_col    = 10'd0;
    vid1.vidin_d      = 16'hD00D;
    vid1.vidout_req   = 1'b1;
    vid1.vidout_frame = 1'b0;
    vid1.vidout_row   = 10'd0;
    vid1.vidout_col   = 10'd0;
    vid2.vidin_req    = 1'b0;
    vid2.vidin_frame  = 1'b0;
    vid2.vidin_row    = 10'd0;
    vid2.vidin_col    = 10'd0;
    vid2.vidin_d      = 16'h0000;
    vid2.vidout_req   = 1'b0;
    vid2.vidout_frame = 1'b0;
    vid2.vidout_row   = 10'd0;
    vid2.vidout_col   = 10'd0;

    // Reset values
    #22;
    check("rst_mem_req", mem1.mem_req, 0);
    check("rst_mem_we", mem1.mem_we, 0);
    check("rst_mem_addr", mem1.mem_addr, 0);
    check("rst_mem_wdata", mem1.mem_wdata, 0);
    check("rst_vidin_ack", vid1.vidin_ack, 0);
    check("rst_vidout_ack", vid1.vidout_ack, 0);
    check("rst_vidout_d", vid1.vidout_d, 0);
    check("rst_wrap_req", mem2.mem_req, 0);

    // Contention from reset: read, write, read
    mem_lat = 0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    n0 = op_cnt;
    for (int c = 0; c < 400 && (op_cnt - n0) < 32; c++) @(negedge clk_sys);
    vid1.vidin_req  = 1'b0;
    vid1.vidout_req = 1'b0;
    check("cont_ops", op_cnt - n0, 32);
    for (int i = 0; i < 32; i++)
      check($sformatf("cont_we%0d", i), op_we[n0 + i], (i >= 8 && i < 24) ? 1 : 0);
    repeat (4) @(negedge clk_sys);
    check("cont_idle_req", mem1.mem_req, 0);

    // Single write burst, memory acks 2 cycles after each request
    mem_lat           = 2;
    n0                = op_cnt;
    vin0              = vin_acks;
    vid1.vidin_frame  = 1'b1;
    vid1.vidin_row    = 10'd3;
    vid1.vidin_col    = 10'd32;
    vid1.vidin_d      = 16'hA000;
    vid1.vidin_req    = 1'b1;
    acks              = 0;
    for (int c = 0; c < 300 && acks < 16; c++) begin
      @(negedge clk_sys);
      if (vid1.vidin_ack === 1'b1) begin
        acks++;
        vid1.vidin_d = 16'hA000 + 16'(acks);
      end
    end
    vid1.vidin_req = 1'b0;
    repeat (6) @(negedge clk_sys);
    check("wr_ops", op_cnt - n0, 16);
    check("wr_acks", vin_acks - vin0, 16);
    check("wr_idle_req", mem1.mem_req, 0);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("wr_we%0d", k), op_we[n0 + k], 1);
      check($sformatf("wr_addr%0d", k), op_addr[n0 + k], 32'h080C20 + k);
      check($sformatf("wr_data%0d", k), op_data[n0 + k], 32'hA000 + k);
    end

    // Single read burst, ack every cycle: mem_req must stay high throughout
    mem_lat           = 0;
    vid1.vidout_frame = 1'b0;
    vid1.vidout_row   = 10'd5;
    vid1.vidout_col   = 10'd0;
    vid1.vidout_req   = 1'b1;
    @(negedge clk_sys);
    check("rd_first_req", mem1.mem_req, 1);
    check("rd_first_we", mem1.mem_we, 0);
    check("rd_first_addr", mem1.mem_addr, 32'h1400);
    check("rd_first_noack", vid1.vidout_ack, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_sys);
      check($sformatf("rd_ack%0d", k), vid1.vidout_ack, 1);
      check($sformatf("rd_d%0d", k), vid1.vidout_d, 32'h1400 + k);
      check($sformatf("rd_req%0d", k), mem1.mem_req, (k < 7) ? 1 : 0);
      if (k < 7) check($sformatf("rd_addr%0d", k), mem1.mem_addr, 32'h1401 + k);
    end
    vid1.vidout_req = 1'b0;
    @(negedge clk_sys);
    check("rd_hold_ack", vid1.vidout_ack, 0);
    check("rd_hold_req", mem1.mem_req, 0);
    repeat (2) @(negedge clk_sys);

    // Write abort after 5th ack
    mem_lat          = 1;
    n0               = op_cnt;
    vid1.vidin_frame = 1'b0;
    vid1.vidin_row   = 10'd1;
    vid1.vidin_col   = 10'd4;
    vid1.vidin_d     = 16'hB000;
    vid1.vidin_req   = 1'b1;
    acks             = 0;
    for (int c = 0; c < 200 && acks < 5; c++) begin
      @(negedge clk_sys);
      if (vid1.vidin_ack === 1'b1) begin
        acks++;
        vid1.vidin_d = 16'hB000 + 16'(acks);
      end
    end
    vid1.vidin_req = 1'b0;
    repeat (10) @(negedge clk_sys);
    check("ab_ops", op_cnt - n0, 5);
    check("ab_idle_req", mem1.mem_req, 0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("ab_addr%0d", k), op_addr[n0 + k], 32'h404 + k);
      check($sformatf("ab_data%0d", k), op_data[n0 + k], 32'hB000 + k);
    end

    // Next burst must start at beat 0
    n0             = op_cnt;
    vid1.vidin_col = 10'd100;
    vid1.vidin_d   = 16'hC000;
    vid1.vidin_req = 1'b1;
    acks           = 0;
    for (int c = 0; c < 50 && acks < 1; c++) begin
      @(negedge clk_sys);
      if (vid1.vidin_ack === 1'b1) acks++;
    end
    vid1.vidin_req = 1'b0;
    repeat (6) @(negedge clk_sys);
    check("ab2_ops", op_cnt - n0, 1);
    check("ab2_addr", op_addr[n0], 32'h464);
    check("ab2_data", op_data[n0], 32'hC000);

    // Asynchronous reset after the 3rd read ack
    mem_lat           = 0;
    vid1.vidout_row   = 10'd2;
    vid1.vidout_col   = 10'd0;
    vid1.vidout_req   = 1'b1;
    acks              = 0;
    for (int c = 0; c < 50 && acks < 3; c++) begin
      @(negedge clk_sys);
      if (vid1.vidout_ack === 1'b1) acks++;
    end
    check("rst_pre_ack", vid1.vidout_ack, 1);
    check("rst_pre_req", mem1.mem_req, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_req", mem1.mem_req, 0);
    check("rst_async_ack", vid1.vidout_ack, 0);
    check("rst_async_d", vid1.vidout_d, 0);
    vid1.vidout_req = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("rst_idle_req", mem1.mem_req, 0);

    // Fresh read from IDLE, aborted on its first ack: word still delivered
    vid1.vidout_col = 10'd8;
    vid1.vidout_req = 1'b1;
    @(negedge clk_sys);
    check("rab_req", mem1.mem_req, 1);
    check("rab_addr", mem1.mem_addr, 32'h808);
    vid1.vidout_req = 1'b0;
    @(negedge clk_sys);
    check("rab_ack", vid1.vidout_ack, 1);
    check("rab_d", vid1.vidout_d, 32'h0808);
    check("rab_drop", mem1.mem_req, 0);
    @(negedge clk_sys);
    check("rab_ack_end", vid1.vidout_ack, 0);

    // Address wrap on the 20-bit instance
    vid2.vidout_frame = 1'b0;
    vid2.vidout_row   = 10'd0;
    vid2.vidout_col   = 10'd10;
    vid2.vidout_req   = 1'b1;
    @(negedge clk_sys);
    check("wrap_req", mem2.mem_req, 1);
    check("wrap_addr0", mem2.mem_addr, 32'h00002);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_sys);
      check($sformatf("wrap_ack%0d", k), vid2.vidout_ack, 1);
      check($sformatf("wrap_d%0d", k), vid2.vidout_d, 32'h0002 + k);
      if (k < 7) check($sformatf("wrap_addr%0d", k + 1), mem2.mem_addr, 32'h00003 + k);
    end
    vid2.vidout_req = 1'b0;
    @(negedge clk_sys);
    check("wrap_end_req", mem2.mem_req, 0);
    check("wrap_end_ack", vid2.vidout_ack, 0);

    check("ack_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
